// File: rtl/mlh_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mlh_uart_pkg                                                         |
// | Shared UART framing types and host command codes for the node link.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mlh_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } tx_state_t;

    // Packet-level sequencing: one byte on the wire, or inter-byte idle
    typedef enum logic [1:0] {
        PKT_IDLE = 2'd0,
        PKT_BYTE = 2'd1,
        PKT_GAP  = 2'd2
    } pkt_state_t;

    localparam int PKT_BYTES      = 6;
    localparam int BITS_PER_FRAME = 10;

    localparam logic [7:0] LOAD_D1 = 8'd0;
    localparam logic [7:0] LOAD_D2 = 8'd1;
    localparam logic [7:0] OUT_RES = 8'd2;
    localparam logic [7:0] MUL     = 8'd5;
    localparam logic [7:0] MUL_ADD = 8'd6;

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_byte_tx                                                         |
// | 8N1 byte serialiser, LSB first, with chained back-to-back launch.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_byte_tx
    import mlh_uart_pkg::*;
#(
    parameter int BAUD_DIV = 430
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_byte_valid,
    input  logic [7:0] i_byte_data,
    output logic       o_byte_done,
    output logic       o_tx
);

    localparam int              c_cnt_w     = $clog2(BAUD_DIV);
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(BAUD_DIV - 1);

    tx_state_t          r_state, w_state;
    logic [c_cnt_w-1:0] r_cnt,   w_cnt;
    logic [2:0]         r_bit,   w_bit;
    logic [7:0]         r_shift, w_shift;
    logic               r_tx,    w_tx;
    logic               w_bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_tx    <= w_tx;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_bit     = r_bit;
        w_shift   = r_shift;
        w_tx      = r_tx;
        w_bit_end = (r_cnt == c_baud_last);

        if (r_state != IDLE) begin
            w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (i_byte_valid) begin
                    w_state = START;
                    w_shift = i_byte_data;
                    w_tx    = 1'b0;
                    w_cnt   = '0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state = DATA;
                    w_bit   = '0;
                    w_tx    = r_shift[0];
                    w_shift = {1'b1, r_shift[7:1]};
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_state = STOP;
                        w_tx    = 1'b1;
                    end else begin
                        w_bit   = r_bit + 1'b1;
                        w_tx    = r_shift[0];
                        w_shift = {1'b1, r_shift[7:1]};
                    end
                end
            end
            STOP: begin
                // A launch presented in the last stop cycle starts the next frame with no idle gap
                if (w_bit_end) begin
                    if (i_byte_valid) begin
                        w_state = START;
                        w_shift = i_byte_data;
                        w_tx    = 1'b0;
                    end else begin
                        w_state = IDLE;
                        w_tx    = 1'b1;
                    end
                end
            end
            default: begin
                w_state = IDLE;
                w_tx    = 1'b1;
                w_cnt   = '0;
            end
        endcase
    end

    assign o_byte_done = (r_state == STOP) && w_bit_end;
    assign o_tx        = r_tx;

endmodule
`default_nettype wire

// File: rtl/resp_packet_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | resp_packet_tx                                                       |
// | Serialises {ADDR, cmd, data[31:0]} as a 6-byte UART response packet. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module resp_packet_tx
    import mlh_uart_pkg::*;
#(
    parameter logic [7:0] ADDR     = 8'd100,
    parameter int         BAUD_DIV = 430,
    parameter int         GAP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send_valid,
    output logic        send_ready,
    input  logic [7:0]  send_cmd,
    input  logic [31:0] send_data,
    output logic        uart_tx,
    output logic        busy
);

    localparam int                 c_cnt_w     = $clog2(BAUD_DIV);
    localparam logic [c_cnt_w-1:0] c_baud_last = c_cnt_w'(BAUD_DIV - 1);
    localparam int                 c_gap_w     = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [c_gap_w-1:0] c_gap_last  = c_gap_w'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [2:0]         c_last_idx  = 3'(PKT_BYTES - 1);

    pkt_state_t         r_state,   w_state;
    logic [47:0]        r_shift,   w_shift;
    logic [2:0]         r_idx,     w_idx;
    logic [c_cnt_w-1:0] r_gap_cnt, w_gap_cnt;
    logic [c_gap_w-1:0] r_gap_bit, w_gap_bit;
    logic               w_accept;
    logic               w_byte_valid;
    logic [7:0]         w_byte_data;
    logic               w_byte_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= PKT_IDLE;
            r_shift   <= '0;
            r_idx     <= '0;
            r_gap_cnt <= '0;
            r_gap_bit <= '0;
        end else begin
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_idx     <= w_idx;
            r_gap_cnt <= w_gap_cnt;
            r_gap_bit <= w_gap_bit;
        end
    end

    assign send_ready = (r_state == PKT_IDLE);
    assign busy       = ~send_ready;
    assign w_accept   = send_valid && send_ready;

    // Bytes 1..5 are always read from [15:8]; the register rotates so every bit stays live
    always_comb begin
        w_state      = r_state;
        w_shift      = r_shift;
        w_idx        = r_idx;
        w_gap_cnt    = r_gap_cnt;
        w_gap_bit    = r_gap_bit;
        w_byte_valid = 1'b0;
        w_byte_data  = r_shift[15:8];

        case (r_state)
            PKT_IDLE: begin
                w_byte_data = ADDR;
                if (w_accept) begin
                    w_byte_valid = 1'b1;
                    w_state      = PKT_BYTE;
                    w_shift      = {send_data, send_cmd, ADDR};
                    w_idx        = '0;
                end
            end
            PKT_BYTE: begin
                if (w_byte_done) begin
                    if (r_idx == c_last_idx) begin
                        w_state = PKT_IDLE;
                        w_idx   = '0;
                    end else begin
                        w_idx = r_idx + 1'b1;
                        if (GAP_BITS > 0) begin
                            w_state   = PKT_GAP;
                            w_gap_cnt = '0;
                            w_gap_bit = '0;
                        end else begin
                            w_byte_valid = 1'b1;
                            w_shift      = {r_shift[7:0], r_shift[47:8]};
                        end
                    end
                end
            end
            PKT_GAP: begin
                if (r_gap_cnt == c_baud_last) begin
                    w_gap_cnt = '0;
                    if (r_gap_bit == c_gap_last) begin
                        w_byte_valid = 1'b1;
                        w_shift      = {r_shift[7:0], r_shift[47:8]};
                        w_state      = PKT_BYTE;
                    end else begin
                        w_gap_bit = r_gap_bit + 1'b1;
                    end
                end else begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                end
            end
            default: begin
                w_state = PKT_IDLE;
            end
        endcase
    end

    uart_byte_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte_tx (
        .clk          (clk),
        .rst          (rst),
        .i_byte_valid (w_byte_valid),
        .i_byte_data  (w_byte_data),
        .o_byte_done  (w_byte_done),
        .o_tx         (uart_tx)
    );

endmodule
`default_nettype wire

// File: tb/tb_resp_packet_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_resp_packet_tx                                                    |
// | Directed bench: two parameterisations, UART receiver, timing checks. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_resp_packet_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_a, ready_a, tx_a, busy_a;
    logic [7:0]  cmd_a;
    logic [31:0] data_a;
    logic        valid_b, ready_b, tx_b, busy_b;
    logic [7:0]  cmd_b;
    logic [31:0] data_b;
    int          cyc = 0;
    int          n_err = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    resp_packet_tx #(.ADDR(8'd100), .BAUD_DIV(8), .GAP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .send_valid(valid_a), .send_ready(ready_a),
        .send_cmd(cmd_a), .send_data(data_a), .uart_tx(tx_a), .busy(busy_a)
    );

    resp_packet_tx #(.ADDR(8'd101), .BAUD_DIV(2), .GAP_BITS(0)) dut_b (
        .clk(clk), .rst(rst), .send_valid(valid_b), .send_ready(ready_b),
        .send_cmd(cmd_b), .send_data(data_b), .uart_tx(tx_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic line(input int sel);
        return (sel != 0) ? tx_b : tx_a;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel != 0) ? ready_b : ready_a;
    endfunction

    // Called on a negedge; detects the start bit, then samples mid-bit
    task automatic rx_byte(input int sel, input int baud, output logic [7:0] b, output int st);
        int n;
        b  = '0;
        st = -1;
        n  = 0;
        while (line(sel) !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rx_start_timeout", 48'(n < 2000), 48'd1);
        if (n >= 2000) return;
        st = cyc;
        repeat (baud / 2) @(negedge clk);
        check("rx_start_mid", 48'(line(sel)), 48'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (baud) @(negedge clk);
            b[k] = line(sel);
        end
        repeat (baud) @(negedge clk);
        check("rx_stop", 48'(line(sel)), 48'd1);
    endtask

    task automatic rx_packet(input int sel, input int baud, input logic [47:0] exp,
                             input string tag, output int first_st, output int last_st);
        logic [7:0] b;
        int         st;
        first_st = -1;
        last_st  = -1;
        for (int i = 0; i < 6; i++) begin
            rx_byte(sel, baud, b, st);
            check($sformatf("%s_byte%0d", tag, i), 48'(b), 48'(exp[i*8 +: 8]));
            if (i == 0) first_st = st;
            last_st = st;
        end
    endtask

    task automatic wait_ready(input int sel, input int budget, output int edge_cyc);
        int n;
        n = 0;
        while (rdy(sel) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 48'(n < budget), 48'd1);
        edge_cyc = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  acc, acc2, f, l, e, n, lows;
        bit  saw;
        rst = 1'b1;
        valid_a = 1'b0; cmd_a = '0; data_a = '0;
        valid_b = 1'b0; cmd_b = '0; data_b = '0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            check("rst_a", {45'd0, tx_a, ready_a, busy_a}, 48'b110);
            check("rst_b", {45'd0, tx_b, ready_b, busy_b}, 48'b110);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_a", {45'd0, tx_a, ready_a, busy_a}, 48'b110);

        // Single packet
        valid_a = 1'b1; cmd_a = 8'd2; data_a = 32'h0403_0201;
        @(negedge clk);
        acc = cyc;
        valid_a = 1'b0;
        check("t2_start_bit", 48'(tx_a), 48'd0);
        check("t2_ready_low", 48'(ready_a), 48'd0);
        check("t2_busy", 48'(busy_a), 48'd1);
        rx_packet(0, 8, {32'h0403_0201, 8'd2, 8'd100}, "t2", f, l);
        check("t2_byte_span", 48'(l - f), 48'd440);
        wait_ready(0, 100, e);
        check("t2_duration", 48'(e - acc), 48'd520);

        // Request while busy is ignored; inputs changed mid-packet do not leak in
        @(negedge clk);
        valid_a = 1'b1; cmd_a = 8'd1; data_a = 32'h1234_5678;
        @(negedge clk);
        valid_a = 1'b0;
        fork
            rx_packet(0, 8, {32'h1234_5678, 8'd1, 8'd100}, "t3", f, l);
            begin
                repeat (150) @(negedge clk);
                valid_a = 1'b1; cmd_a = 8'd6; data_a = 32'hFFFF_FFFF;
                @(negedge clk);
                valid_a = 1'b0; data_a = 32'h0;
            end
        join
        wait_ready(0, 100, e);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || ready_a !== 1'b1) lows++;
        end
        check("t3_no_second_pkt", 48'(lows), 48'd0);

        // Back-to-back with send_valid held
        valid_a = 1'b1; cmd_a = 8'd5; data_a = 32'h0000_0028;
        @(negedge clk);
        acc = cyc;
        check("t4_start1", 48'(tx_a), 48'd0);
        cmd_a = 8'd6; data_a = 32'h1122_3344;
        rx_packet(0, 8, {32'h0000_0028, 8'd5, 8'd100}, "t4a", f, l);
        n = 0; saw = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (ready_a === 1'b1) saw = 1'b1;
            if (tx_a === 1'b0) break;
        end
        acc2 = cyc;
        valid_a = 1'b0;
        check("t4_start2", 48'(tx_a), 48'd0);
        check("t4_ready_between", 48'(saw), 48'd1);
        check("t4_separation", 48'((acc2 - acc) >= 521), 48'd1);
        rx_packet(0, 8, {32'h1122_3344, 8'd6, 8'd100}, "t4b", f, l);
        wait_ready(0, 100, e);

        // Reset during data bit 3 of byte 2 (byte 0x55: bit2=1, bit3=0)
        @(negedge clk);
        valid_a = 1'b1; cmd_a = 8'd2; data_a = 32'h0000_0055;
        @(negedge clk);
        acc = cyc;
        valid_a = 1'b0;
        while (cyc < acc + 204) @(negedge clk);
        check("t5_b2_bit2", 48'(tx_a), 48'd1);
        while (cyc < acc + 210) @(negedge clk);
        check("t5_b2_bit3", 48'(tx_a), 48'd0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_line", 48'(tx_a), 48'd1);
        check("t5_rst_busy", 48'(busy_a), 48'd0);
        rst = 1'b0;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || ready_a !== 1'b1) lows++;
        end
        check("t5_quiet_after_rst", 48'(lows), 48'd0);
        valid_a = 1'b1; cmd_a = 8'd1; data_a = 32'hDEAD_BEEF;
        @(negedge clk);
        acc = cyc;
        valid_a = 1'b0;
        rx_packet(0, 8, {32'hDEAD_BEEF, 8'd1, 8'd100}, "t5", f, l);
        wait_ready(0, 100, e);
        check("t5_duration", 48'(e - acc), 48'd520);

        // Parameter sweep: ADDR=101, GAP_BITS=0, BAUD_DIV=2
        @(negedge clk);
        valid_b = 1'b1; cmd_b = 8'd6; data_b = 32'h80FF_0001;
        @(negedge clk);
        acc = cyc;
        valid_b = 1'b0;
        check("t6_start_bit", 48'(tx_b), 48'd0);
        rx_packet(1, 2, {32'h80FF_0001, 8'd6, 8'd101}, "t6", f, l);
        check("t6_byte_span", 48'(l - f), 48'd100);
        wait_ready(1, 20, e);
        check("t6_duration", 48'(e - acc), 48'd120);
        check("t6_idle_line", 48'(tx_b), 48'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/resp_packet_tx.md
# resp_packet_tx

Response packet transmitter for the perceptron node: the return path of the host command link. It accepts a command echo plus a 32-bit result from the node core and serialises them as a 6-byte packet over a UART line (8N1, LSB first). The packet format matches host-to-node command packets: node address, command, then 4 data bytes. It sits between the perceptron datapath and the node's `uart_tx` pin.

## Interface
- `ADDR`, 100, node address byte sent as packet byte 0.
- `BAUD_DIV`, 430, clock cycles per bit (50 MHz clock, ~116 kbaud); legal range ≥2.
- `GAP_BITS`, 1, idle (mark) bit-times inserted between consecutive bytes of one packet; 0 allowed.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `send_valid` in 1: request to send a packet.
- `send_ready` out 1: transmitter idle; a packet is accepted on `send_valid && send_ready`.
- `send_cmd` in 8: command byte echoed as packet byte 1.
- `send_data` in 32: result word; bytes 2..5 = `[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`.
- `uart_tx` out 1: serial line, idle high.
- `busy` out 1: packet in flight, equal to `!send_ready`.

## Operation
- Reset values: `uart_tx`=1, `send_ready`=1, `busy`=0, baud counter=0, byte index=0, FSM=IDLE.
- On acceptance, `ADDR`, `send_cmd` and `send_data` are captured into a 48-bit shift register. Later input changes have no effect on the packet.
- Packet FSM states:
  - IDLE: wait for a handshake → START.
  - START: drive 0 → DATA.
  - DATA: drive 8 bits, LSB first → STOP.
  - STOP: drive 1. If more bytes remain → GAP when `GAP_BITS`>0, else START. After the last byte → IDLE.
  - GAP: hold 1 for `GAP_BITS` bit-times → START.
- Byte index counts 0..5. It advances at the end of STOP and does not wrap within a packet.
- Each bit state lasts exactly `BAUD_DIV` cycles. The baud counter runs 0..`BAUD_DIV`-1 and wraps at each bit boundary.
- `send_valid` asserted while busy is ignored, not queued. The requester holds `send_valid` until it sees `send_ready`.
- `send_valid` asserted in the same cycle the last stop bit ends is not accepted. `send_ready` rises on the following edge.
- Synchronous `rst` mid-packet aborts the packet:
  - `uart_tx`=1 on the next edge.
  - Partial byte is discarded, with no stop-bit completion.
  - `send_ready`=1 after the edge where `rst` is sampled low.

## Timing
- Acceptance edge N: `uart_tx` falls (start bit) on edge N+1 and `send_ready` falls at N+1.
- Bit k of byte b begins at edge N+1 + (b·(10+`GAP_BITS`) + 1 + k)·`BAUD_DIV`.
- Total packet duration: (60 + 5·`GAP_BITS`)·`BAUD_DIV` cycles. No gap follows byte 5.
- `send_ready` returns high one cycle after the final stop bit completes. Back-to-back packets are therefore separated by at least one idle cycle plus the handshake cycle.
- `uart_tx` is driven from a flop, so the output is glitch-free.

## Structure
- Shared package `mlh_uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP, GAP.
  - `PKT_BYTES`=6, `BITS_PER_FRAME`=10.
  - Command codes shared with the receive side: LOAD_D1=0, LOAD_D2=1, OUT_RES=2, MUL=5, MUL_ADD=6.
- Sub-module `uart_byte_tx`: byte serialiser (START/DATA/STOP, baud counter, `byte_valid`/`byte_done` handshake).
- Top: packet sequencer, shift register, byte index, gap timer.

## Test plan
All scenarios use `BAUD_DIV`=8 and `GAP_BITS`=1 unless noted.
- Reset: hold `rst` 3 cycles → `uart_tx`=1, `send_ready`=1, `busy`=0 throughout and after.
- Single packet, cmd=2, data=0x04030201 → a bench UART receiver decodes 100, 2, 1, 2, 3, 4. Start bit at acceptance+1. `send_ready` returns exactly 520 cycles after acceptance+1.
- Ignored request: pulse `send_valid` mid-packet with cmd=6 → packet unchanged and no second packet follows.
- Back-to-back: hold `send_valid` with cmd=5, data=0x28, then change to cmd=6 → two packets (100,5,0x28,0,0,0) and (100,6,…). Line is high ≥1 cycle between them.
- Reset mid-packet: assert `rst` during data bit 3 of byte 2 → `uart_tx`=1 next cycle. A new packet after release is bit-exact.
- Parameter sweep: `ADDR`=101, `GAP_BITS`=0, `BAUD_DIV`=2 → byte 0 = 101, stop bit immediately followed by next start bit, duration 120 cycles.
